datapath_ctrl_fsm: RTL and testbench
====================================

// Module: datapath_ctrl_fsm
// PURPOSE
//  Multicycle Moore control unit for the MIPS-subset datapath. Sequences the PC, memory, IR, A/B,
//  ALUOut and EPC registers and drives the ALU operand muxes (ALUSrcA, ALUSrcBControl) every cycle.
//  Sits beside the datapath top; consumes opcode/funct from IR and zero/overflow from the ALU.
//  Supports add, sub, and (R-type), addi, lw, sw, beq, bne, j; overflow and bad-opcode exceptions.
// PARAMETERS
//  MEM_WAIT   1        extra cycles a memory read needs before data is valid (0..7)
//  SP_INIT    32'd227  value written to $29 in the RESET_ST state
//  EXC_VECTOR 32'd0    PC value loaded on any exception
// PORTS
//  clk            in   1  clock, all state updates on rising edge
//  reset          in   1  asynchronous, active-high; forces RESET_ST
//  opcode         in   6  IR[31:26]
//  funct          in   6  IR[5:0]
//  zero           in   1  ALU result == 0
//  overflow       in   1  ALU signed overflow
//  PCWrite        out  1  load PC from PCSource mux
//  IorD           out  1  0 = PC addresses memory, 1 = ALUOut
//  MemWrite       out  1  memory write strobe
//  IRWrite        out  1  load IR from memory data
//  RegDst         out  2  00 rt, 01 rd, 10 $31, 11 $29
//  MemToReg       out  2  00 ALUOut, 01 MDR, 10 SP_INIT constant
//  RegWrite       out  1  register file write enable
//  ABWrite        out  1  load A and B from register file
//  ALUOutWrite    out  1  load ALUOut
//  EPCWrite       out  1  load EPC from ALU result
//  ALUSrcA        out  1  0 = PC, 1 = A
//  ALUSrcBControl out  2  00 sign-ext imm, 01 const 4, 10 B, 11 sign-ext imm << 2
//  ALUControl     out  3  001 add, 010 sub, 011 and, 000 pass A
//  PCSource       out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 EXC_VECTOR
//  state_dbg      out  5  current state encoding (debug)
// BEHAVIOUR
//  - Moore: all outputs decode from the state register only; no input reaches an output combinationally.
//  - Reset (async): state <= RESET_ST, wait counter <= 0; every output 0 except in RESET_ST decode.
//  - RESET_ST (1 cy): RegWrite=1, RegDst=11, MemToReg=10 -> $29 <= SP_INIT; next FETCH.
//  - FETCH: IorD=0, ALUSrcA=0, ALUSrcBControl=01, ALUControl=add, PCSource=00, PCWrite=1 (PC <= PC+4).
//  - FETCH_WAIT: held MEM_WAIT cycles by 3-bit counter (skipped when MEM_WAIT=0); last cycle IRWrite=1.
//  - DECODE: ABWrite=1; ALUOut <= PC + (imm<<2) (ALUSrcA=0, SrcB=11, add, ALUOutWrite=1).
//    Dispatch: R-type known funct -> EXEC_R; unknown funct or opcode -> EXC_OPCODE;
//    addi -> ADDI_EXEC; lw/sw -> MEM_ADDR; beq -> BEQ; bne -> BNE; j -> JUMP.
//  - EXEC_R: SrcA=1, SrcB=10, ALUControl by funct, ALUOutWrite=1; overflow on add/sub -> EXC_OVF else WB_R.
//  - WB_R: RegDst=01, MemToReg=00, RegWrite=1 -> FETCH.  ADDI_EXEC/ADDI_WB same with SrcB=00, RegDst=00.
//  - MEM_ADDR: SrcA=1, SrcB=00, add, ALUOutWrite=1 -> LW_READ (lw) or SW_WRITE (sw).
//  - LW_READ: IorD=1, MEM_WAIT counted as in fetch -> LW_WB (RegDst=00, MemToReg=01, RegWrite=1).
//  - SW_WRITE: IorD=1, MemWrite=1 for exactly 1 cycle -> FETCH.
//  - BEQ/BNE: SrcA=1, SrcB=10, sub; PCSource=01; PCWrite = zero (beq) / !zero (bne) -> FETCH.
//    Exception to strict Moore: branch PCWrite is state AND zero, the only Mealy term.
//  - JUMP: PCSource=10, PCWrite=1 -> FETCH.
//  - EXC_OVF/EXC_OPCODE: SrcA=0, SrcB=01, sub, EPCWrite=1 (EPC <= PC-4); PCSource=11, PCWrite=1 -> FETCH.
//  - Overflow is ignored in every state except EXEC_R/ADDI_EXEC; and never raises EXC_OVF.
//  - Reset asserted mid-instruction aborts it; no partial writes after reset edge.
// STRUCTURE
//  Package ctrl_pkg: state encodings, opcode/funct constants, ALUControl and mux-select codes.
//  Sub-module mem_wait_ctr (load, done) shared by FETCH_WAIT and LW_READ; rest is one FSM.
// TESTING
//  reset high 3 cy, release -> one cycle RegWrite=1, RegDst=11, MemToReg=10, then FETCH with PCWrite=1.
//  MEM_WAIT=2, opcode=0 funct=0x20 -> FETCH,WAIT x2 (IRWrite last),DECODE,EXEC_R,WB_R: 6 cy.
//  beq zero=1 -> PCWrite=1 PCSource=01 in BEQ; zero=0 -> PCWrite=0; bne inverse.
//  add with overflow=1 in EXEC_R -> EXC_OVF: EPCWrite=1, PCSource=11, no RegWrite ever asserted.
//  opcode=0x3F -> EXC_OPCODE after DECODE; sw -> MemWrite high exactly 1 cy, IorD=1.
//  reset pulsed during LW_READ -> outputs zero immediately, restart in RESET_ST, no RegWrite.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: states, opcodes,
// mux selects and the registered control-word layout.
package ctrl_pkg;

  localparam int unsigned STATE_W = 5;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    RESET_ST   = 5'd0,
    FETCH      = 5'd1,
    FETCH_WAIT = 5'd2,
    DECODE     = 5'd3,
    EXEC_R     = 5'd4,
    WB_R       = 5'd5,
    ADDI_EXEC  = 5'd6,
    ADDI_WB    = 5'd7,
    MEM_ADDR   = 5'd8,
    LW_READ    = 5'd9,
    LW_WB      = 5'd10,
    SW_WRITE   = 5'd11,
    BEQ        = 5'd12,
    BNE        = 5'd13,
    JUMP       = 5'd14,
    EXC_OVF    = 5'd15,
    EXC_OPCODE = 5'd16
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;

  typedef enum logic [2:0] {
    ALU_PASSA = 3'b000,
    ALU_ADD   = 3'b001,
    ALU_SUB   = 3'b010,
    ALU_AND   = 3'b011
  } alu_ctrl_t;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;
  localparam logic [1:0] REGDST_SP = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_SPINIT = 2'b10;

  localparam logic [1:0] SRCB_IMM    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_B      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       ab_write;
    logic       aluout_write;
    logic       epc_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    alu_ctrl_t  alu_ctrl;
    logic [1:0] pc_source;
  } ctrl_out_t;

  function automatic logic funct_known(input logic [OP_W-1:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
  endfunction

  function automatic alu_ctrl_t funct_alu(input logic [OP_W-1:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      default: return ALU_PASSA;
    endcase
  endfunction

  // Control word for a state; ir_write and r_op only matter in fetch and EXEC_R.
  function automatic ctrl_out_t decode_state(input state_t st, input logic ir_write,
                                             input alu_ctrl_t r_op);
    ctrl_out_t c;
    c = '0;
    case (st)
      RESET_ST: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = REGDST_SP;
        c.mem_to_reg = M2R_SPINIT;
      end
      FETCH: begin
        c.pc_write  = 1'b1;
        c.ir_write  = ir_write;
        c.alu_src_b = SRCB_FOUR;
        c.alu_ctrl  = ALU_ADD;
        c.pc_source = PCSRC_ALU;
      end
      FETCH_WAIT: c.ir_write = ir_write;
      DECODE: begin
        c.ab_write     = 1'b1;
        c.aluout_write = 1'b1;
        c.alu_src_b    = SRCB_IMM_SH;
        c.alu_ctrl     = ALU_ADD;
      end
      EXEC_R: begin
        c.alu_src_a    = 1'b1;
        c.alu_src_b    = SRCB_B;
        c.alu_ctrl     = r_op;
        c.aluout_write = 1'b1;
      end
      WB_R: begin
        c.reg_dst   = REGDST_RD;
        c.reg_write = 1'b1;
      end
      ADDI_EXEC, MEM_ADDR: begin
        c.alu_src_a    = 1'b1;
        c.alu_src_b    = SRCB_IMM;
        c.alu_ctrl     = ALU_ADD;
        c.aluout_write = 1'b1;
      end
      ADDI_WB: c.reg_write = 1'b1;
      LW_READ: c.iord = 1'b1;
      LW_WB: begin
        c.mem_to_reg = M2R_MDR;
        c.reg_write  = 1'b1;
      end
      SW_WRITE: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      BEQ, BNE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_ctrl  = ALU_SUB;
        c.pc_source = PCSRC_ALUOUT;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      EXC_OVF, EXC_OPCODE: begin
        c.alu_src_b = SRCB_FOUR;
        c.alu_ctrl  = ALU_SUB;
        c.epc_write = 1'b1;
        c.pc_source = PCSRC_EXC;
        c.pc_write  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Down-counter timing memory-read latency; done/almost are registered views
// of "count is 0" / "count is 1".
import ctrl_pkg::*;

module mem_wait_ctr (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] ld_val,
  output logic             done,
  output logic             almost
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt;
    if (load)
      cnt_n = ld_val;
    else if (cnt != '0)
      cnt_n = cnt - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      done   <= 1'b1;
      almost <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      done   <= (cnt_n == '0);
      almost <= (cnt_n == CNT_W'(1));
    end
  end

endmodule

// File: rtl/datapath_ctrl_fsm.sv
// Multicycle Moore control unit for the MIPS-subset datapath. Control word is
// registered from the next state; branch PCWrite is the only term using an input.
import ctrl_pkg::*;

module datapath_ctrl_fsm #(
  parameter int unsigned MEM_WAIT   = 1,
  parameter logic [31:0] SP_INIT    = 32'd227,
  parameter logic [31:0] EXC_VECTOR = 32'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       RegWrite,
  output logic       ABWrite,
  output logic       ALUOutWrite,
  output logic       EPCWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcBControl,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSource,
  output logic [4:0] state_dbg
);

  // Fetch waits MEM_WAIT cycles after FETCH; a load spends 1 + MEM_WAIT cycles in LW_READ.
  localparam logic [CNT_W-1:0] FETCH_LD   = CNT_W'((MEM_WAIT == 0) ? 0 : MEM_WAIT - 1);
  localparam logic [CNT_W-1:0] LW_LD      = CNT_W'(MEM_WAIT);
  localparam logic             IR_IN_FETCH = (MEM_WAIT == 0);
  localparam logic             IR_FIRST_WAIT = (MEM_WAIT == 1);

  if (MEM_WAIT > 7) begin : g_bad_wait
    $error("MEM_WAIT must be 0..7");
  end
  if (EXC_VECTOR[1:0] != 2'b00) begin : g_bad_vec
    $error("EXC_VECTOR must be word aligned");
  end
  if (SP_INIT == 32'd0) begin : g_bad_sp
    $error("SP_INIT must be nonzero");
  end

  state_t           state;
  state_t           nxt;
  logic             boot_done;
  ctrl_out_t        ctl_q;
  ctrl_out_t        ctl_d;
  logic             ir_next;
  logic             ctr_load;
  logic [CNT_W-1:0] ctr_val;
  logic             ctr_done;
  logic             ctr_almost;
  logic             is_arith;
  logic             br_take;

  mem_wait_ctr u_wait (
    .clk    (clk),
    .reset  (reset),
    .load   (ctr_load),
    .ld_val (ctr_val),
    .done   (ctr_done),
    .almost (ctr_almost)
  );

  assign is_arith = (funct == FN_ADD) || (funct == FN_SUB);

  // Next state, wait-counter control and the IRWrite qualifier for the next cycle.
  always_comb begin
    nxt      = state;
    ir_next  = IR_IN_FETCH;
    ctr_load = 1'b0;
    ctr_val  = FETCH_LD;
    case (state)
      RESET_ST: nxt = boot_done ? FETCH : RESET_ST;
      FETCH: begin
        if (MEM_WAIT == 0) begin
          nxt = DECODE;
        end else begin
          nxt      = FETCH_WAIT;
          ctr_load = 1'b1;
          ctr_val  = FETCH_LD;
          ir_next  = IR_FIRST_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (ctr_done) nxt = DECODE;
        else          ir_next = ctr_almost;
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE:     nxt = funct_known(funct) ? EXEC_R : EXC_OPCODE;
          OP_ADDI:      nxt = ADDI_EXEC;
          OP_LW, OP_SW: nxt = MEM_ADDR;
          OP_BEQ:       nxt = BEQ;
          OP_BNE:       nxt = BNE;
          OP_J:         nxt = JUMP;
          default:      nxt = EXC_OPCODE;
        endcase
      end
      EXEC_R:    nxt = (overflow && is_arith) ? EXC_OVF : WB_R;
      ADDI_EXEC: nxt = overflow ? EXC_OVF : ADDI_WB;
      MEM_ADDR: begin
        if (opcode == OP_LW) begin
          nxt      = LW_READ;
          ctr_load = 1'b1;
          ctr_val  = LW_LD;
        end else begin
          nxt = SW_WRITE;
        end
      end
      LW_READ: if (ctr_done) nxt = LW_WB;
      WB_R, ADDI_WB, LW_WB, SW_WRITE, BEQ, BNE, JUMP, EXC_OVF, EXC_OPCODE: nxt = FETCH;
      default: nxt = RESET_ST;
    endcase
    ctl_d = decode_state(nxt, ir_next, funct_alu(funct));
  end

  // First clock after reset release re-enters RESET_ST so its write is seen exactly once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RESET_ST;
      boot_done <= 1'b0;
      ctl_q     <= '0;
    end else begin
      state     <= nxt;
      boot_done <= 1'b1;
      ctl_q     <= ctl_d;
    end
  end

  assign br_take = ((state == BEQ) && zero) || ((state == BNE) && !zero);

  assign PCWrite        = ctl_q.pc_write | br_take;
  assign IorD           = ctl_q.iord;
  assign MemWrite       = ctl_q.mem_write;
  assign IRWrite        = ctl_q.ir_write;
  assign RegDst         = ctl_q.reg_dst;
  assign MemToReg       = ctl_q.mem_to_reg;
  assign RegWrite       = ctl_q.reg_write;
  assign ABWrite        = ctl_q.ab_write;
  assign ALUOutWrite    = ctl_q.aluout_write;
  assign EPCWrite       = ctl_q.epc_write;
  assign ALUSrcA        = ctl_q.alu_src_a;
  assign ALUSrcBControl = ctl_q.alu_src_b;
  assign ALUControl     = ctl_q.alu_ctrl;
  assign PCSource       = ctl_q.pc_source;
  assign state_dbg      = state;

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// Directed bench for datapath_ctrl_fsm with MEM_WAIT=2; control words are hand-coded.
module tb_datapath_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       PCWrite, IorD, MemWrite, IRWrite, RegWrite, ABWrite, ALUOutWrite, EPCWrite, ALUSrcA;
  logic [1:0] RegDst, MemToReg, ALUSrcBControl, PCSource;
  logic [2:0] ALUControl;
  logic [4:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  datapath_ctrl_fsm #(.MEM_WAIT(2), .SP_INIT(32'd227), .EXC_VECTOR(32'd0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
    .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .ABWrite(ABWrite), .ALUOutWrite(ALUOutWrite),
    .EPCWrite(EPCWrite), .ALUSrcA(ALUSrcA), .ALUSrcBControl(ALUSrcBControl),
    .ALUControl(ALUControl), .PCSource(PCSource), .state_dbg(state_dbg)
  );

  // {PCWrite,IorD,MemWrite,IRWrite}{RegDst}{MemToReg}{RegWrite,ABWrite,ALUOutWrite,EPCWrite}
  // {ALUSrcA}{ALUSrcB}{ALUControl}{PCSource}
  logic [19:0] ctl;
  assign ctl = {PCWrite, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ABWrite,
                ALUOutWrite, EPCWrite, ALUSrcA, ALUSrcBControl, ALUControl, PCSource};

  localparam logic [19:0] CW_ZERO   = 20'd0;
  localparam logic [19:0] CW_RST    = {4'b0000, 2'b11, 2'b10, 4'b1000, 1'b0, 2'b00, 3'b000, 2'b00};
  localparam logic [19:0] CW_FETCH  = {4'b1000, 2'b00, 2'b00, 4'b0000, 1'b0, 2'b01, 3'b001, 2'b00};
  localparam logic [19:0] CW_WAITIR = {4'b0001, 2'b00, 2'b00, 4'b0000, 1'b0, 2'b00, 3'b000, 2'b00};
  localparam logic [19:0] CW_DECODE = {4'b0000, 2'b00, 2'b00, 4'b0110, 1'b0, 2'b11, 3'b001, 2'b00};
  localparam logic [19:0] CW_R_ADD  = {4'b0000, 2'b00, 2'b00, 4'b0010, 1'b1, 2'b10, 3'b001, 2'b00};
  localparam logic [19:0] CW_R_SUB  = {4'b0000, 2'b00, 2'b00, 4'b0010, 1'b1, 2'b10, 3'b010, 2'b00};
  localparam logic [19:0] CW_R_AND  = {4'b0000, 2'b00, 2'b00, 4'b0010, 1'b1, 2'b10, 3'b011, 2'b00};
  localparam logic [19:0] CW_WB_R   = {4'b0000, 2'b01, 2'b00, 4'b1000, 1'b0, 2'b00, 3'b000, 2'b00};
  localparam logic [19:0] CW_IMM_EX = {4'b0000, 2'b00, 2'b00, 4'b0010, 1'b1, 2'b00, 3'b001, 2'b00};
  localparam logic [19:0] CW_ADDIWB = {4'b0000, 2'b00, 2'b00, 4'b1000, 1'b0, 2'b00, 3'b000, 2'b00};
  localparam logic [19:0] CW_LWREAD = {4'b0100, 2'b00, 2'b00, 4'b0000, 1'b0, 2'b00, 3'b000, 2'b00};
  localparam logic [19:0] CW_LW_WB  = {4'b0000, 2'b00, 2'b01, 4'b1000, 1'b0, 2'b00, 3'b000, 2'b00};
  localparam logic [19:0] CW_SW     = {4'b0110, 2'b00, 2'b00, 4'b0000, 1'b0, 2'b00, 3'b000, 2'b00};
  localparam logic [19:0] CW_BR_T   = {4'b1000, 2'b00, 2'b00, 4'b0000, 1'b1, 2'b10, 3'b010, 2'b01};
  localparam logic [19:0] CW_JUMP   = {4'b1000, 2'b00, 2'b00, 4'b0000, 1'b0, 2'b00, 3'b000, 2'b10};
  localparam logic [19:0] CW_EXC    = {4'b1000, 2'b00, 2'b00, 4'b0001, 1'b0, 2'b01, 3'b010, 2'b11};

  localparam logic [4:0] S_RST = 5'd0,  S_FETCH = 5'd1,  S_WAIT = 5'd2,  S_DEC = 5'd3;
  localparam logic [4:0] S_EXR = 5'd4,  S_WBR = 5'd5,    S_AEX = 5'd6,   S_AWB = 5'd7;
  localparam logic [4:0] S_MEMA = 5'd8, S_LWR = 5'd9,    S_LWWB = 5'd10, S_SW = 5'd11;
  localparam logic [4:0] S_BEQ = 5'd12, S_BNE = 5'd13,   S_J = 5'd14,    S_OVF = 5'd15;
  localparam logic [4:0] S_OPC = 5'd16;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_st(input string tag, input logic [19:0] w, input logic [4:0] s);
    check({tag, ".ctl"}, 32'(ctl), 32'(w));
    check({tag, ".st"}, 32'(state_dbg), 32'(s));
  endtask

  // Entered at the FETCH cycle; returns at the DECODE cycle.
  task automatic fetch_dec(input string tag, input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
    expect_st({tag, ".fetch"}, CW_FETCH, S_FETCH);
    step();
    expect_st({tag, ".wait1"}, CW_ZERO, S_WAIT);
    step();
    expect_st({tag, ".wait2"}, CW_WAITIR, S_WAIT);
    step();
    expect_st({tag, ".decode"}, CW_DECODE, S_DEC);
  endtask

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; overflow = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_st("rst_hold", CW_ZERO, S_RST);
    reset = 1'b0;
    step(); expect_st("reset_st", CW_RST, S_RST);
    step();

    fetch_dec("add", 6'h00, 6'h20);
    step(); expect_st("add.exec", CW_R_ADD, S_EXR);
    step(); expect_st("add.wb", CW_WB_R, S_WBR);
    step();

    fetch_dec("sub", 6'h00, 6'h22);
    step(); expect_st("sub.exec", CW_R_SUB, S_EXR);
    step(); expect_st("sub.wb", CW_WB_R, S_WBR);
    step();

    fetch_dec("and", 6'h00, 6'h24);
    step(); overflow = 1'b1; expect_st("and.exec", CW_R_AND, S_EXR);
    step(); overflow = 1'b0; expect_st("and.wb", CW_WB_R, S_WBR);
    step();

    fetch_dec("addovf", 6'h00, 6'h20);
    step(); overflow = 1'b1; expect_st("addovf.exec", CW_R_ADD, S_EXR);
    step(); overflow = 1'b0; expect_st("addovf.exc", CW_EXC, S_OVF);
    step();

    fetch_dec("addi", 6'h08, 6'h00);
    step(); expect_st("addi.exec", CW_IMM_EX, S_AEX);
    step(); expect_st("addi.wb", CW_ADDIWB, S_AWB);
    step();

    zero = 1'b1;
    fetch_dec("beq", 6'h04, 6'h00);
    step(); expect_st("beq.taken", CW_BR_T, S_BEQ);
    zero = 1'b0; #1;
    check("beq.not_taken", 32'(PCWrite), 32'd0);
    step();

    fetch_dec("bne", 6'h05, 6'h00);
    step(); expect_st("bne.taken", CW_BR_T, S_BNE);
    zero = 1'b1; #1;
    check("bne.not_taken", 32'(PCWrite), 32'd0);
    zero = 1'b0;
    step();

    fetch_dec("j", 6'h02, 6'h00);
    step(); expect_st("j.jump", CW_JUMP, S_J);
    step();

    fetch_dec("badop", 6'h3F, 6'h00);
    step(); expect_st("badop.exc", CW_EXC, S_OPC);
    step();

    fetch_dec("badfn", 6'h00, 6'h25);
    step(); expect_st("badfn.exc", CW_EXC, S_OPC);
    step();

    fetch_dec("sw", 6'h2B, 6'h00);
    step(); expect_st("sw.addr", CW_IMM_EX, S_MEMA);
    step(); expect_st("sw.write", CW_SW, S_SW);
    step(); expect_st("sw.after", CW_FETCH, S_FETCH);

    fetch_dec("lw", 6'h23, 6'h00);
    step(); expect_st("lw.addr", CW_IMM_EX, S_MEMA);
    step(); expect_st("lw.read1", CW_LWREAD, S_LWR);
    step(); expect_st("lw.read2", CW_LWREAD, S_LWR);
    step(); expect_st("lw.read3", CW_LWREAD, S_LWR);
    step(); expect_st("lw.wb", CW_LW_WB, S_LWWB);
    step();

    fetch_dec("lwrst", 6'h23, 6'h00);
    step(); expect_st("lwrst.addr", CW_IMM_EX, S_MEMA);
    step(); expect_st("lwrst.read1", CW_LWREAD, S_LWR);
    #2 reset = 1'b1;
    #1 expect_st("lwrst.async", CW_ZERO, S_RST);
    step(); expect_st("lwrst.held", CW_ZERO, S_RST);
    reset = 1'b0;
    step(); expect_st("lwrst.reset_st", CW_RST, S_RST);
    step(); expect_st("lwrst.refetch", CW_FETCH, S_FETCH);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
